mac_psum_accum: RTL and testbench



---
 rtl/mac_psum_accum.sv | 103 ++++++++++
 tb/tb_mac_psum_accum.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mac_psum_accum.sv
// Framed partial-sum accumulator: sums a valid/ready stream of MAC partial sums per frame
// and presents total, beat count and overflow. Define MAC_PSUM_ACCUM_SAT_EN to saturate instead of wrap.
module mac_psum_accum #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             psum_valid,
  output logic             psum_ready,
  input  logic [IN_W-1:0]  psum_data,
  input  logic             psum_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [CNT_W-1:0] res_beats,
  output logic             res_ovf
);

  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  beats;
  logic              ovf;
  logic              in_xfer;
  logic              out_xfer;
  logic [SUM_W-1:0]  sum;

  // Handshake flags decode registered state only, so res_ready never reaches psum_ready.
  assign psum_ready = (state != HOLD);
  assign res_valid  = (state == HOLD);
  assign in_xfer    = psum_valid && psum_ready;
  assign out_xfer   = res_valid && res_ready;

  // One extra bit exposes the carry-out that marks accumulator overflow.
  assign sum = {1'b0, acc} + SUM_W'(psum_data);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: next_state gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (in_xfer) begin
          state_nxt = psum_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_xfer) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      beats <= '0;
      ovf   <= 1'b0;
    end else if (in_xfer) begin
      if (state == IDLE) begin
        acc   <= ACC_W'(psum_data);
        beats <= CNT_W'(1);
        ovf   <= 1'b0;
      end else begin
`ifdef MAC_PSUM_ACCUM_SAT_EN
        // Once clamped, any further nonzero beat carries out again, so the clamp persists.
        acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        acc <= sum[ACC_W-1:0];
`endif
        ovf <= ovf | sum[ACC_W];
        if (beats != '1) begin
          beats <= beats + CNT_W'(1);
        end
      end
    end
  end

  // Results read straight from the registers, which stay put until the next frame's first beat.
  assign res_data  = acc;
  assign res_beats = beats;
  assign res_ovf   = ovf;

endmodule

// File: tb/tb_mac_psum_accum.sv
// Directed bench for mac_psum_accum: table of whole frames plus hand-written
// backpressure, mid-frame reset and back-to-back sequences.
module tb_mac_psum_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psum_valid;
  logic        psum_ready;
  logic [15:0] psum_data;
  logic        psum_last;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_data;
  logic [7:0]  res_beats;
  logic        res_ovf;

  int checks = 0;
  int errors = 0;

  mac_psum_accum #(.IN_W(16), .ACC_W(24), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .psum_valid(psum_valid),
    .psum_ready(psum_ready),
    .psum_data (psum_data),
    .psum_last (psum_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_beats (res_beats),
    .res_ovf   (res_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          n;
    logic [15:0] val;
    bit          gap;
    logic [23:0] exp_data;
    logic [7:0]  exp_beats;
    bit          exp_ovf;
  } frame_vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat has transferred.
  task automatic send_beat(input logic [15:0] d, input bit last);
    int waited = 0;
    psum_valid = 1'b1;
    psum_data  = d;
    psum_last  = last;
    while (!psum_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready_timeout", {31'd0, psum_ready}, 32'd1);
    @(negedge clk);
    // Garbage on data/last while idle must be ignored.
    psum_valid = 1'b0;
    psum_data  = 16'hDEAD;
    psum_last  = 1'b1;
  endtask

  task automatic check_result(input string name, input logic [23:0] d, input logic [7:0] b, input bit o);
    check({name, "_valid"}, {31'd0, res_valid}, 32'd1);
    check({name, "_data"},  {8'd0, res_data},   {8'd0, d});
    check({name, "_beats"}, {24'd0, res_beats}, {24'd0, b});
    check({name, "_ovf"},   {31'd0, res_ovf},   {31'd0, o});
  endtask

  task automatic accept_result(input string name, input logic [23:0] d);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({name, "_idle_ready"}, {31'd0, psum_ready}, 32'd1);
    check({name, "_idle_valid"}, {31'd0, res_valid},  32'd0);
    check({name, "_held_data"},  {8'd0, res_data},    {8'd0, d});
  endtask

  frame_vec_t vecs[6];

  initial begin
    vecs[0] = '{"single",   1,   16'h1234, 1'b0, 24'h001234, 8'd1,   1'b0};
    vecs[1] = '{"gapped4",  4,   16'hFFFF, 1'b1, 24'h03FFFC, 8'd4,   1'b0};
    vecs[2] = '{"fill256",  256, 16'hFFFF, 1'b0, 24'hFFFF00, 8'd255, 1'b0};
`ifdef MAC_PSUM_ACCUM_SAT_EN
    vecs[3] = '{"ovf257",   257, 16'hFFFF, 1'b0, 24'hFFFFFF, 8'd255, 1'b1};
`else
    vecs[3] = '{"ovf257",   257, 16'hFFFF, 1'b0, 24'h00FEFF, 8'd255, 1'b1};
`endif
    vecs[4] = '{"ovf_clear", 3,  16'h0001, 1'b0, 24'h000003, 8'd3,   1'b0};
    vecs[5] = '{"zero",     2,   16'h0000, 1'b1, 24'h000000, 8'd2,   1'b0};

    rst_n      = 1'b0;
    psum_valid = 1'b0;
    psum_data  = 16'h0;
    psum_last  = 1'b0;
    res_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_psum_ready", {31'd0, psum_ready}, 32'd1);
    check("rst_res_valid",  {31'd0, res_valid},  32'd0);
    check("rst_res_data",   {8'd0, res_data},    32'd0);
    check("rst_res_beats",  {24'd0, res_beats},  32'd0);
    check("rst_res_ovf",    {31'd0, res_ovf},    32'd0);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        send_beat(vecs[i].val, k == vecs[i].n - 1);
        if (vecs[i].gap && k != vecs[i].n - 1) @(negedge clk);
      end
      check_result(vecs[i].name, vecs[i].exp_data, vecs[i].exp_beats, vecs[i].exp_ovf);
      accept_result(vecs[i].name, vecs[i].exp_data);
    end

    // Backpressure: pending beat must wait until the result leaves.
    send_beat(16'h0042, 1'b1);
    psum_valid = 1'b1;
    psum_data  = 16'h0007;
    psum_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_psum_ready", {31'd0, psum_ready}, 32'd0);
      check_result("bp_hold", 24'h000042, 8'd1, 1'b0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_after_xfer_ready", {31'd0, psum_ready}, 32'd1);
    check("bp_after_xfer_valid", {31'd0, res_valid},  32'd0);
    @(negedge clk);
    psum_valid = 1'b0;
    check_result("bp_new_frame", 24'h000007, 8'd1, 1'b0);
    accept_result("bp_new_frame", 24'h000007);

    // Asynchronous reset mid-frame.
    send_beat(16'h0100, 1'b0);
    send_beat(16'h0100, 1'b0);
    check("mid_partial", {8'd0, res_data}, 32'h200);
    #2 rst_n = 1'b0;
    #1;
    check("arst_res_data",  {8'd0, res_data},   32'd0);
    check("arst_res_beats", {24'd0, res_beats}, 32'd0);
    check("arst_res_valid", {31'd0, res_valid}, 32'd0);
    check("arst_res_ovf",   {31'd0, res_ovf},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(16'h0005, 1'b1);
    check_result("post_rst", 24'h000005, 8'd1, 1'b0);
    accept_result("post_rst", 24'h000005);

    // Back-to-back frames with res_ready tied high.
    res_ready = 1'b1;
    send_beat(16'h0010, 1'b0);
    send_beat(16'h0020, 1'b1);
    check_result("b2b_a", 24'h000030, 8'd2, 1'b0);
    send_beat(16'h0003, 1'b1);
    check_result("b2b_b", 24'h000003, 8'd1, 1'b0);
    @(negedge clk);
    res_ready = 1'b0;
    check("b2b_done_valid", {31'd0, res_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
